// File: rtl/npc_pkg.sv
// Shared encodings for the PC redirect unit: next-PC opcodes, FSM states, default vectors.
package npc_pkg;

   typedef enum logic [2:0] {
      NPC_SEQ  = 3'd0,
      NPC_BR   = 3'd1,
      NPC_J    = 3'd2,
      NPC_JR   = 3'd3,
      NPC_ERET = 3'd4
   } npcop_t;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } npc_state_t;

   localparam logic [31:0] NPC_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] NPC_EXC_VEC   = 32'h0000_4180;

   // Encodings 5-7 fall back to sequential fetch, so only 1..4 redirect.
   function automatic logic is_redirect_op(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd4);
   endfunction

endpackage

// File: rtl/npc_target_mux.sv
// Combinational next-PC target select: interrupt vector beats control-flow ops, which beat pc+4.
module npc_target_mux
   import npc_pkg::*;
#(
   parameter int              AW      = 32,
   parameter logic [AW-1:0]   EXC_VEC = AW'(NPC_EXC_VEC)
) (
   input  logic [2:0]    npcop,
   input  logic          intreq,
   input  logic [AW-1:0] pc4,
   input  logic [AW-1:0] id_pc4,
   input  logic [AW-1:0] imm,
   input  logic [25:0]   instr_index,
   input  logic [AW-1:0] rs_val,
   input  logic [AW-1:0] epc,
   output logic [AW-1:0] target,
   output logic          redirect
);

   always_comb begin
      target   = pc4;
      redirect = intreq | is_redirect_op(npcop);
      case (npcop)
         NPC_BR:   target = id_pc4 + (imm << 2);
         NPC_J:    target = {id_pc4[AW-1:28], instr_index, 2'b00};
         NPC_JR:   target = rs_val;
         NPC_ERET: target = epc;
         default:  target = pc4;
      endcase
      if (intreq) target = EXC_VEC;
   end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with valid/ready handshake and a one-entry pending-redirect slot.
// Optional macro NPC_ALIGN_CHK_EN enables the misaligned-fetch flag pc_adel.
module pc_redirect_unit
   import npc_pkg::*;
#(
   parameter int            AW        = 32,
   parameter logic [AW-1:0] RESET_VEC = AW'(NPC_RESET_VEC),
   parameter logic [AW-1:0] EXC_VEC   = AW'(NPC_EXC_VEC)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic [2:0]    npcop,
   input  logic [AW-1:0] id_pc4,
   input  logic [AW-1:0] imm,
   input  logic [25:0]   instr_index,
   input  logic [AW-1:0] rs_val,
   input  logic [AW-1:0] epc,
   input  logic          intreq,
   input  logic          fetch_ready,
   output logic          fetch_valid,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc4,
   output logic          pend,
   output logic          pc_adel
);

   npc_state_t    state;
   logic [AW-1:0] pend_pc;
   logic [AW-1:0] target;
   logic          redirect;
   logic          accept;

   assign pc4         = pc + AW'(4);
   assign fetch_valid = (state != ST_BOOT);
   assign pend        = (state == ST_PEND);
   assign accept      = fetch_valid & fetch_ready & ~stall;

   npc_target_mux #(
      .AW      (AW),
      .EXC_VEC (EXC_VEC)
   ) u_target_mux (
      .npcop       (npcop),
      .intreq      (intreq),
      .pc4         (pc4),
      .id_pc4      (id_pc4),
      .imm         (imm),
      .instr_index (instr_index),
      .rs_val      (rs_val),
      .epc         (epc),
      .target      (target),
      .redirect    (redirect)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_BOOT;
         pc      <= RESET_VEC;
         pend_pc <= '0;
      end else begin
         case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN: begin
               if (accept) begin
                  pc <= target;
               end else if (redirect) begin
                  pend_pc <= target;
                  state   <= ST_PEND;
               end
            end
            ST_PEND: begin
               // A late interrupt supersedes the held redirect, even on the accepting cycle.
               if (intreq) pend_pc <= EXC_VEC;
               if (accept) begin
                  pc    <= intreq ? EXC_VEC : pend_pc;
                  state <= ST_RUN;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

`ifdef NPC_ALIGN_CHK_EN
   assign pc_adel = fetch_valid & (pc[1:0] != 2'b00);
`else
   assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        reset, stall, intreq, fetch_ready;
   logic [2:0]  npcop;
   logic [31:0] id_pc4, imm, rs_val, epc;
   logic [25:0] instr_index;
   logic        fetch_valid, pend, pc_adel;
   logic [31:0] pc, pc4;

   int total = 0;
   int bad   = 0;

   // Behavioural model: "booting" flag, fetch pc, and an optional held redirect.
   logic        m_boot;
   logic [31:0] m_pc;
   logic        m_held;
   logic [31:0] m_held_pc;

   // Hand-computed expectations pinned by the directed section.
   logic        lit_vld = 1'b0;
   logic [31:0] lit_pc;
   logic        lit_pend, lit_fv, lit_adel_chk, lit_adel;

`ifdef NPC_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   always #5 clk = ~clk;

   pc_redirect_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .npcop       (npcop),
      .id_pc4      (id_pc4),
      .imm         (imm),
      .instr_index (instr_index),
      .rs_val      (rs_val),
      .epc         (epc),
      .intreq      (intreq),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .pc          (pc),
      .pc4         (pc4),
      .pend        (pend),
      .pc_adel     (pc_adel)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: model every cycle, literal pins when posted.
   always @(negedge clk) begin
      logic exp_adel;
      exp_adel = ALIGN && !m_boot && (m_pc[1:0] != 2'b00);
      cmp("model_pc", pc, m_pc);
      cmp("model_pc4", pc4, m_pc + 32'd4);
      cmp("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
      cmp("model_pend", {31'd0, pend}, {31'd0, m_held});
      cmp("model_pc_adel", {31'd0, pc_adel}, {31'd0, exp_adel});
      if (lit_vld) begin
         cmp("lit_pc", pc, lit_pc);
         cmp("lit_pend", {31'd0, pend}, {31'd0, lit_pend});
         cmp("lit_fetch_valid", {31'd0, fetch_valid}, {31'd0, lit_fv});
         if (lit_adel_chk) cmp("lit_pc_adel", {31'd0, pc_adel}, {31'd0, lit_adel});
      end
   end

   function automatic logic [31:0] spec_target(input logic [31:0] cur);
      if (intreq) return 32'h0000_4180;
      case (npcop)
         3'd1:    return id_pc4 + imm * 32'd4;
         3'd2:    return {id_pc4[31:28], instr_index, 2'b00};
         3'd3:    return rs_val;
         3'd4:    return epc;
         default: return cur + 32'd4;
      endcase
   endfunction

   task automatic model_reset();
      m_boot    = 1'b1;
      m_pc      = 32'h0000_3000;
      m_held    = 1'b0;
      m_held_pc = 32'h0;
   endtask

   // Advance one clock with the current inputs and update the model alongside.
   task automatic step();
      logic        acc, wants;
      logic        n_boot, n_held;
      logic [31:0] n_pc, n_held_pc;
      acc       = !m_boot && fetch_ready && !stall;
      wants     = intreq || (npcop >= 3'd1 && npcop <= 3'd4);
      n_boot    = 1'b0;
      n_pc      = m_pc;
      n_held    = m_held;
      n_held_pc = m_held_pc;
      if (m_boot) begin
         n_boot = 1'b0;
      end else if (!m_held) begin
         if (acc) n_pc = spec_target(m_pc);
         else if (wants) begin
            n_held    = 1'b1;
            n_held_pc = spec_target(m_pc);
         end
      end else begin
         if (intreq) n_held_pc = 32'h0000_4180;
         if (acc) begin
            n_pc   = n_held_pc;
            n_held = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_boot    = n_boot;
      m_pc      = n_pc;
      m_held    = n_held;
      m_held_pc = n_held_pc;
   endtask

   task automatic expect_lit(input logic [31:0] p, input logic pd, input logic fv,
                             input logic achk, input logic a);
      lit_pc       = p;
      lit_pend     = pd;
      lit_fv       = fv;
      lit_adel_chk = achk;
      lit_adel     = a;
      lit_vld      = 1'b1;
      @(negedge clk);
      #1;
      lit_vld = 1'b0;
   endtask

   task automatic assert_reset();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      reset       = 1'b0;
      stall       = 1'b0;
      intreq      = 1'b0;
      fetch_ready = 1'b1;
      npcop       = 3'd0;
      id_pc4      = '0;
      imm         = '0;
      rs_val      = '0;
      epc         = '0;
      instr_index = '0;
      model_reset();
      expect_lit(32'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
      release_reset();

      // Boot cycle, then sequential fetch.
      step(); expect_lit(32'h3000, 1'b0, 1'b1, 1'b0, 1'b0);
      step(); expect_lit(32'h3004, 1'b0, 1'b1, 1'b0, 1'b0);
      step(); expect_lit(32'h3008, 1'b0, 1'b1, 1'b0, 1'b0);

      // Branch with negative offset, then jump.
      npcop = 3'd1; id_pc4 = 32'h3010; imm = 32'hFFFF_FFFE;
      step(); expect_lit(32'h3008, 1'b0, 1'b1, 1'b0, 1'b0);
      npcop = 3'd2; instr_index = 26'h0000C40;
      step(); expect_lit(32'h3100, 1'b0, 1'b1, 1'b0, 1'b0);

      // JR while memory not ready: held, then taken.
      fetch_ready = 1'b0; npcop = 3'd3; rs_val = 32'h3400;
      step(); expect_lit(32'h3100, 1'b1, 1'b1, 1'b0, 1'b0);
      fetch_ready = 1'b1; npcop = 3'd0;
      step(); expect_lit(32'h3400, 1'b0, 1'b1, 1'b0, 1'b0);

      // Interrupt pulse under stall beats ERET; ERET is ignored while held.
      stall = 1'b1; intreq = 1'b1; npcop = 3'd4; epc = 32'h3050;
      step(); expect_lit(32'h3400, 1'b1, 1'b1, 1'b0, 1'b0);
      intreq = 1'b0;
      step(); expect_lit(32'h3400, 1'b1, 1'b1, 1'b0, 1'b0);
      stall = 1'b0;
      step(); expect_lit(32'h4180, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset while holding a redirect clears everything without a clock edge.
      npcop = 3'd3; fetch_ready = 1'b0; rs_val = 32'h3402;
      step(); expect_lit(32'h4180, 1'b1, 1'b1, 1'b0, 1'b0);
      assert_reset();
      expect_lit(32'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
      release_reset();
      npcop = 3'd0; fetch_ready = 1'b1;
      step(); expect_lit(32'h3000, 1'b0, 1'b1, 1'b0, 1'b0);

      // Misaligned JR target.
      npcop = 3'd3; rs_val = 32'h3402;
      step(); expect_lit(32'h3402, 1'b0, 1'b1, 1'b1, ALIGN);
      npcop = 3'd0;
      step(); expect_lit(32'h3406, 1'b0, 1'b1, 1'b1, ALIGN);

      // Randomized traffic, with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            assert_reset();
            @(posedge clk);
            release_reset();
            #1;
         end
         stall       = ($urandom_range(0, 3) == 0);
         fetch_ready = ($urandom_range(0, 9) < 7);
         intreq      = ($urandom_range(0, 9) == 0);
         npcop       = 3'($urandom_range(0, 7));
         id_pc4      = $urandom;
         imm         = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
         instr_index = 26'($urandom);
         rs_val      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         epc         = $urandom;
         step();
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
